// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan feeder.
//   BLANK_CODE      : nibble the downstream decoder renders as all-segments-off
//   AN_* / DP_*     : active-low anode and decimal-point levels
//   lz_blank_digit  : leading-zero suppression test for one digit position
package seg_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic        AN_OFF     = 1'b1;
    localparam logic        AN_ON      = 1'b0;
    localparam logic        DP_OFF     = 1'b1;
    localparam logic        DP_ON      = 1'b0;
    localparam int unsigned MAX_DIGITS = 8;

    // Digit i is a leading zero when it is not the rightmost digit and every
    // nibble from i up to the most significant used digit (n-1) is zero.
    // nibbles is zero-padded to MAX_DIGITS so one function serves any width.
    function automatic logic lz_blank_digit(
        input logic [4*MAX_DIGITS-1:0] nibbles,
        input int unsigned             n,
        input int unsigned             i
    );
        logic nonzero;
        nonzero = 1'b0;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (k >= i && k < n && nibbles[4*k +: 4] != 4'h0) begin
                nonzero = 1'b1;
            end
        end
        return (i != 0) && !nonzero;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Bus between the scan feeder and its producer/display side.
//   digits, dp_in, upd, lz_suppress : display data, update strobe, config
//   x, an, dp, frame_start          : decoder nibble, anodes, dp, frame pulse
// master = producer/observer side, slave = seg_scan_mux.
interface seg_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    upd;
    logic                    lz_suppress;
    logic [3:0]              x;
    logic [NUM_DIGITS-1:0]   an;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output digits, dp_in, upd, lz_suppress,
        input  x, an, dp, frame_start
    );

    modport slave (
        input  digits, dp_in, upd, lz_suppress,
        output x, an, dp, frame_start
    );
endinterface

// File: rtl/seg_slot_timer.sv
// Refresh slot timer: cnt runs 0..REFRESH_DIV-1, idx advances on each wrap.
//   clk, rst_n      : clock, synchronous active-low reset
//   idx             : digit currently owning the slot
//   in_blank        : slot is in its anti-ghosting blank window
//   frame_boundary  : cnt==0 && idx==0
module seg_slot_timer #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV),
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             in_blank,
    output logic             frame_boundary
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        in_blank       = (cnt < CNT_W'(BLANK_CYCLES));
        frame_boundary = (cnt == '0) && (idx == '0);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed display scan feeder for a hex-to-7-segment decoder.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seg_scan_mux_if slave (digits/dp_in/upd/lz_suppress in;
//                x/an/dp/frame_start out, all registered)
// Updates are staged and only committed to the shadow at a frame boundary,
// so a frame is never drawn from a mix of old and new digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    logic [IDX_W-1:0]               idx;
    logic                           in_blank;
    logic                           frame_boundary;

    logic [NUM_DIGITS-1:0][3:0]     staging;
    logic [NUM_DIGITS-1:0][3:0]     shadow;
    logic [NUM_DIGITS-1:0]          dp_staging;
    logic [NUM_DIGITS-1:0]          dp_shadow;
    logic                           pending;

    logic [4*MAX_DIGITS-1:0]        shadow_ext;
    logic [NUM_DIGITS-1:0]          lz_mask;
    logic [NUM_DIGITS-1:0]          an_show;

    seg_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .idx            (idx),
        .in_blank       (in_blank),
        .frame_boundary (frame_boundary)
    );

    // An upd landing on the boundary cycle bypasses staging so it is shown
    // in the frame that starts now rather than one frame later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            staging    <= {NUM_DIGITS{BLANK_CODE}};
            shadow     <= {NUM_DIGITS{BLANK_CODE}};
            dp_staging <= '0;
            dp_shadow  <= '0;
            pending    <= 1'b0;
        end else if (frame_boundary) begin
            if (bus.upd) begin
                shadow    <= bus.digits;
                dp_shadow <= bus.dp_in;
            end else if (pending) begin
                shadow    <= staging;
                dp_shadow <= dp_staging;
            end
            pending <= 1'b0;
        end else if (bus.upd) begin
            staging    <= bus.digits;
            dp_staging <= bus.dp_in;
            pending    <= 1'b1;
        end
    end

    always_comb begin
        shadow_ext                   = '0;
        shadow_ext[4*NUM_DIGITS-1:0] = shadow;
        lz_mask                      = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            lz_mask[i] = lz_blank_digit(shadow_ext, NUM_DIGITS, i);
        end
        an_show      = '1;
        an_show[idx] = AN_ON;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.x           <= BLANK_CODE;
            bus.an          <= {NUM_DIGITS{AN_OFF}};
            bus.dp          <= DP_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= frame_boundary;
            if (in_blank) begin
                bus.x  <= BLANK_CODE;
                bus.an <= {NUM_DIGITS{AN_OFF}};
                bus.dp <= DP_OFF;
            end else begin
                bus.x  <= (bus.lz_suppress && lz_mask[idx]) ? BLANK_CODE : shadow[idx];
                bus.an <= an_show;
                // Decimal point is independent of zero suppression.
                bus.dp <= dp_shadow[idx] ? DP_ON : DP_OFF;
            end
        end
    end

endmodule
